// File: rtl/jump_trajectory.sv
// Ballistic jump trajectory: steps a fixed-point parabola once per physics tick and reports distance/height/landing.
// Latency: FLY entered 1 cycle after enable; each tick's result is registered (visible the cycle after the tick edge).
// Backpressure: none; level-sensitive enable, dropping it aborts a flight or releases DONE on the next edge.
module jump_trajectory #(
  parameter int TICK_DIV = 419_583,  // clock cycles per physics tick, >= 2
  parameter int GRAVITY  = 1         // vertical velocity decrement per tick, 1..15
) (
  input  logic        clk_jump,
  input  logic        rst_jump,
  input  logic        i_jump_en,
  input  logic [10:0] i_jump_v_init,
  output logic        o_jump_done,
  output logic [10:0] o_jump_dist,
  output logic [8:0]  o_jump_height,
  output logic        o_jump_busy
);

  // Prescaler must hold 0..TICK_DIV-1.
  localparam int              PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [8:0]       GRAV     = 9'(GRAVITY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        v0_q, v0_d;         // latched launch velocity
  logic [8:0]        vy_q, vy_d;         // two's complement vertical velocity
  logic [13:0]       y_acc_q, y_acc_d;   // two's complement height, 1/32 px
  logic [17:0]       x_acc_q, x_acc_d;   // horizontal distance, 1/128 px
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [10:0]       dist_q, dist_d;
  logic [8:0]        height_q, height_d;
  logic              done_q;
  logic              busy_q;

  logic [6:0]        v_clamp;
  logic              tick;
  logic [13:0]       y_next;
  logic [17:0]       x_next;
  logic              land;

  // Launch velocity saturates at the 7-bit maximum.
  assign v_clamp = (i_jump_v_init > 11'd127) ? 7'd127 : i_jump_v_init[6:0];

  // Tick fires on the last prescaler count.
  assign tick = (pre_q == PRE_LAST);

  // Candidate accumulator values for this tick; vy is sign-extended into the height accumulator.
  assign y_next = y_acc_q + {{5{vy_q[8]}}, vy_q};
  assign x_next = x_acc_q + {11'd0, v0_q};

  // Landing when the new height is zero or negative (GRAVITY > 1 can overshoot below ground).
  assign land = y_next[13] | (y_next == 14'd0);

  // Next-state and datapath: launch in IDLE, integrate on ticks in FLY, hold in DONE.
  always_comb begin
    state_d  = state_q;
    v0_d     = v0_q;
    vy_d     = vy_q;
    y_acc_d  = y_acc_q;
    x_acc_d  = x_acc_q;
    pre_d    = pre_q;
    dist_d   = dist_q;
    height_d = height_q;

    case (state_q)
      S_IDLE: begin
        if (i_jump_en) begin
          v0_d     = v_clamp;
          vy_d     = {2'b00, v_clamp};
          y_acc_d  = '0;
          x_acc_d  = '0;
          pre_d    = '0;
          dist_d   = '0;
          height_d = '0;
          state_d  = S_FLY;
        end
      end

      S_FLY: begin
        if (!i_jump_en) begin
          // Abort beats a coincident tick: nothing integrates, outputs hold.
          state_d = S_IDLE;
        end else if (tick) begin
          pre_d   = '0;
          vy_d    = vy_q - GRAV;
          x_acc_d = x_next;
          dist_d  = x_next[17:7];
          if (land) begin
            y_acc_d  = '0;
            height_d = '0;
            state_d  = S_DONE;
          end else begin
            y_acc_d  = y_next;
            height_d = y_next[13:5];
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      S_DONE: begin
        height_d = '0;
        if (!i_jump_en) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, accumulators and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk_jump or negedge rst_jump) begin
    if (!rst_jump) begin
      state_q  <= S_IDLE;
      v0_q     <= '0;
      vy_q     <= '0;
      y_acc_q  <= '0;
      x_acc_q  <= '0;
      pre_q    <= '0;
      dist_q   <= '0;
      height_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      v0_q     <= v0_d;
      vy_q     <= vy_d;
      y_acc_q  <= y_acc_d;
      x_acc_q  <= x_acc_d;
      pre_q    <= pre_d;
      dist_q   <= dist_d;
      height_q <= height_d;
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d == S_FLY);
    end
  end

  assign o_jump_done   = done_q;
  assign o_jump_busy   = busy_q;
  assign o_jump_dist   = dist_q;
  assign o_jump_height = height_q;

endmodule

// File: tb/tb_jump_trajectory.sv
// Directed bench for jump_trajectory with TICK_DIV=4, GRAVITY=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed from the parabola closed forms.
module tb_jump_trajectory;

  logic        clk_jump = 1'b0;
  logic        rst_jump;
  logic        i_jump_en;
  logic [10:0] i_jump_v_init;
  logic        o_jump_done;
  logic [10:0] o_jump_dist;
  logic [8:0]  o_jump_height;
  logic        o_jump_busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc, busy_n, peak, peak_cyc, first_dist;

  jump_trajectory #(
    .TICK_DIV(4),
    .GRAVITY (1)
  ) dut (
    .clk_jump     (clk_jump),
    .rst_jump     (rst_jump),
    .i_jump_en    (i_jump_en),
    .i_jump_v_init(i_jump_v_init),
    .o_jump_done  (o_jump_done),
    .o_jump_dist  (o_jump_dist),
    .o_jump_height(o_jump_height),
    .o_jump_busy  (o_jump_busy)
  );

  always #5 clk_jump = ~clk_jump;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Launch a jump at the current falling edge and follow it until done (bounded).
  // cyc counts falling edges after the FLY-entry edge; tick t is visible at cyc = 4*t.
  task automatic fly(input logic [10:0] v, output int c, output int b, output int pk,
                     output int pk_c, output int fd);
    i_jump_en     = 1'b1;
    i_jump_v_init = v;
    @(negedge clk_jump);
    c    = 0;
    b    = 0;
    pk   = 0;
    pk_c = 0;
    fd   = int'(o_jump_dist);
    if (o_jump_busy) b++;
    while (!o_jump_done && c < 3000) begin
      @(negedge clk_jump);
      c++;
      if (o_jump_busy) b++;
      if (int'(o_jump_height) > pk) begin
        pk   = int'(o_jump_height);
        pk_c = c;
      end
    end
  endtask

  initial begin
    rst_jump      = 1'b0;
    i_jump_en     = 1'b0;
    i_jump_v_init = '0;

    // Reset state.
    repeat (3) @(negedge clk_jump);
    chk("rst_done",   int'(o_jump_done),   0);
    chk("rst_busy",   int'(o_jump_busy),   0);
    chk("rst_dist",   int'(o_jump_dist),   0);
    chk("rst_height", int'(o_jump_height), 0);
    rst_jump = 1'b1;
    @(negedge clk_jump);
    chk("idle_busy", int'(o_jump_busy), 0);

    // v0 = 0: lands on the first tick.
    fly(11'd0, cyc, busy_n, peak, peak_cyc, first_dist);
    chk("v0_cycles", cyc, 4);
    chk("v0_busy_n", busy_n, 4);
    chk("v0_dist",   int'(o_jump_dist),   0);
    chk("v0_height", int'(o_jump_height), 0);
    chk("v0_busy",   int'(o_jump_busy),   0);
    i_jump_en = 1'b0;
    @(negedge clk_jump);
    chk("v0_release", int'(o_jump_done), 0);

    // v0 = 64: 129 ticks, peak 65 at tick 64, final dist 64.
    fly(11'd64, cyc, busy_n, peak, peak_cyc, first_dist);
    chk("v64_cycles",   cyc,      516);
    chk("v64_busy_n",   busy_n,   516);
    chk("v64_peak",     peak,     65);
    chk("v64_peak_cyc", peak_cyc, 256);
    chk("v64_dist",     int'(o_jump_dist),   64);
    chk("v64_height",   int'(o_jump_height), 0);

    // Handshake: done held while enable stays high, falls one edge after it drops.
    repeat (3) @(negedge clk_jump);
    chk("hs_done_held", int'(o_jump_done), 1);
    chk("hs_dist_held", int'(o_jump_dist), 64);
    i_jump_en = 1'b0;
    @(negedge clk_jump);
    chk("hs_done_fall", int'(o_jump_done),   0);
    chk("hs_idle_busy", int'(o_jump_busy),   0);
    chk("hs_idle_dist", int'(o_jump_dist),   64);
    chk("hs_idle_hgt",  int'(o_jump_height), 0);

    // Re-launch with 200: clamps to 127, dist cleared on launch.
    fly(11'd200, cyc, busy_n, peak, peak_cyc, first_dist);
    chk("clamp_first_dist", first_dist, 0);
    chk("clamp_cycles",     cyc,        1020);
    chk("clamp_peak",       peak,       254);
    chk("clamp_peak_cyc",   peak_cyc,   508);
    chk("clamp_dist",       int'(o_jump_dist), 253);
    i_jump_en = 1'b0;
    @(negedge clk_jump);

    // v0 = 127 directly: identical flight.
    fly(11'd127, cyc, busy_n, peak, peak_cyc, first_dist);
    chk("v127_cycles", cyc,  1020);
    chk("v127_peak",   peak, 254);
    chk("v127_dist",   int'(o_jump_dist), 253);
    i_jump_en = 1'b0;
    @(negedge clk_jump);

    // Abort after tick 30: outputs hold, done never rises.
    i_jump_en     = 1'b1;
    i_jump_v_init = 11'd64;
    @(negedge clk_jump);
    repeat (120) @(negedge clk_jump);
    chk("ab_pre_dist",   int'(o_jump_dist),   15);
    chk("ab_pre_height", int'(o_jump_height), 46);
    chk("ab_pre_busy",   int'(o_jump_busy),   1);
    i_jump_en = 1'b0;
    @(negedge clk_jump);
    chk("ab_busy",   int'(o_jump_busy),   0);
    chk("ab_done",   int'(o_jump_done),   0);
    repeat (10) @(negedge clk_jump);
    chk("ab_done_later", int'(o_jump_done),   0);
    chk("ab_dist_hold",  int'(o_jump_dist),   15);
    chk("ab_hgt_hold",   int'(o_jump_height), 46);

    // Abort coinciding with the first tick: no update (tick 1 would give height 2).
    i_jump_en     = 1'b1;
    i_jump_v_init = 11'd64;
    @(negedge clk_jump);
    repeat (3) @(negedge clk_jump);
    i_jump_en = 1'b0;
    @(negedge clk_jump);
    chk("co_busy",   int'(o_jump_busy),   0);
    chk("co_height", int'(o_jump_height), 0);
    chk("co_dist",   int'(o_jump_dist),   0);
    chk("co_done",   int'(o_jump_done),   0);

    // Reset mid-flight at tick 10, then restart with enable held high.
    i_jump_en     = 1'b1;
    i_jump_v_init = 11'd64;
    @(negedge clk_jump);
    repeat (40) @(negedge clk_jump);
    chk("mr_height_t10", int'(o_jump_height), 18);
    chk("mr_dist_t10",   int'(o_jump_dist),   5);
    #1 rst_jump = 1'b0;
    #1;
    chk("mr_async_busy",   int'(o_jump_busy),   0);
    chk("mr_async_dist",   int'(o_jump_dist),   0);
    chk("mr_async_height", int'(o_jump_height), 0);
    chk("mr_async_done",   int'(o_jump_done),   0);
    @(negedge clk_jump);
    rst_jump = 1'b1;
    @(negedge clk_jump);
    chk("mr_restart_busy", int'(o_jump_busy),   1);
    chk("mr_restart_hgt",  int'(o_jump_height), 0);
    repeat (40) @(negedge clk_jump);
    chk("mr_again_height", int'(o_jump_height), 18);
    chk("mr_again_dist",   int'(o_jump_dist),   5);

    i_jump_en = 1'b0;
    repeat (2) @(negedge clk_jump);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jump_trajectory.md
# jump_trajectory

Ballistic trajectory generator for the jumping character. Sits directly downstream of the game state machine: it is launched by the jump enable with a 7-bit initial velocity. It steps a fixed-point parabola at a frame-rate tick and returns live horizontal distance and height, plus a landing flag that ends the jump.

## Interface
- `TICK_DIV`, 419_583: clock cycles per physics tick (~60 Hz at 25.175 MHz); ≥2. Benches use 4.
- `GRAVITY`, 1: vertical velocity decrement per tick, in sub-pixel units; 1..15.
- `clk_jump` in 1: system clock, 25.175 MHz.
- `rst_jump` in 1: asynchronous reset, active-low.
- `i_jump_en` in 1: level. High starts the jump and holds it; low returns the block to idle.
- `i_jump_v_init` in 11: initial velocity. Values >127 clamp to 127.
- `o_jump_done` in/out: out 1. Landing flag, held high in DONE.
- `o_jump_dist` out 11: horizontal distance in pixels.
- `o_jump_height` out 9: height above the block surface in pixels.
- `o_jump_busy` out 1: high in FLY.

## Operation
- States are IDLE, FLY and DONE. Reset value is IDLE.
- Reset clears every register. All outputs reset to 0.
- Internal registers:
  - `v0`: 7-bit, latched velocity.
  - `vy`: 9-bit signed.
  - `y_acc`: 14-bit signed, units of 1/32 px.
  - `x_acc`: 18-bit unsigned, units of 1/128 px.
  - `pre`: prescaler, 0..TICK_DIV-1.
- IDLE, when `i_jump_en`=1:
  - latch `v0`=min(`i_jump_v_init`,127);
  - set `vy`=`v0`, `y_acc`=0, `x_acc`=0, `pre`=0;
  - clear `o_jump_dist` and `o_jump_height`;
  - go to FLY.
- FLY:
  - `pre` increments each cycle. A tick occurs when `pre`=TICK_DIV-1, and `pre` then wraps to 0.
  - On each tick, compute `y_next`=`y_acc`+`vy`. Then apply `vy`←`vy`−GRAVITY and `x_acc`←`x_acc`+`v0`.
  - If `y_next`≤0 (signed): `y_acc`←0, go to DONE.
  - Otherwise: `y_acc`←`y_next`.
- Output mapping:
  - `o_jump_dist`=`x_acc`[17:7].
  - `o_jump_height`=`y_acc`[13:5]. The sign bit is never nonzero at the output.
  - Both outputs are registers, updated on the same edge as the accumulators.
- With GRAVITY=1:
  - flight lasts exactly 2·`v0`+1 ticks;
  - final `x_acc`=`v0`·(2·`v0`+1);
  - peak `y_acc`=`v0`·(`v0`+1)/2, reached after `v0` ticks.
- `v0`=0 lands on the first tick, with dist 0 and height 0.
- DONE:
  - `o_jump_done`=1.
  - Dist holds its final value; height holds 0.
  - When `i_jump_en`=0, go to IDLE. `o_jump_done` drops and dist/height continue to hold.
- Abort: `i_jump_en`=0 during FLY goes to IDLE on the next edge. `o_jump_done` never asserts, and dist/height hold their last values.
- Simultaneous events:
  - A tick on the same cycle as the `i_jump_en` drop: the abort wins and no accumulator update occurs.
  - `i_jump_en` already high on reset release: the jump starts on the first clock edge.
- Arithmetic:
  - `x_acc` maximum is 127·255=32385, which gives no overflow.
  - `vy` minimum is −128 for GRAVITY=1. For GRAVITY>1, `y_next` may be negative; it is clamped to 0 at landing.

## Timing
- IDLE→FLY: 1 cycle after `i_jump_en` is sampled high. The first tick occurs TICK_DIV cycles after entering FLY.
- Tick N updates the outputs, which are visible the cycle after the tick edge.
- `o_jump_done` rises on the same edge as the landing-tick update. Latency from FLY entry to done is (2·`v0`+1)·TICK_DIV cycles.
- `o_jump_done` falls 1 cycle after `i_jump_en` is sampled low. The upstream state machine drops enable the cycle after it samples done, so done is high for ≥2 cycles.
- `o_jump_busy` equals (state==FLY) as a registered decode.
- Reset assertion mid-FLY clears all outputs immediately, asynchronously. After release the block sits in IDLE.

## Test plan
- `v0`=0, TICK_DIV=4 → done rises 4 cycles after FLY entry; dist=0, height=0; busy is high for exactly 4 cycles.
- `v0`=64 → done after 129 ticks (516 cycles); peak height=65 at tick 64; final dist=64; height=0 at done.
- `i_jump_v_init`=200 → clamps to 127; 255 ticks; peak height=254; final dist=253. Matches `v0`=127 cycle-for-cycle.
- `v0`=64, `i_jump_en` dropped after tick 30 → IDLE next cycle; done never asserts; dist=15 (64·30>>7) and height=(64·30−435)>>5=46 hold.
- Full handshake → done held until en low, falls 1 cycle later; re-raising en starts a fresh jump with dist cleared to 0.
- `rst_jump` pulled low mid-flight at tick 10 → all outputs 0 asynchronously; after release with en=1, a new jump starts from tick 0.
